regspace_req_arbiter: RTL and testbench
=======================================

Name: regspace_req_arbiter

Overview:
- Shares one register-space slave port between NUM_REQ masters, e.g. an APB bridge and a debug/DMA config master.
- The slave port uses the split rreq/rack/wreq valid-ready channels of the base register space.
- Round-robin arbitration with at most one transaction in flight.
- Read responses are routed back to the owning master; a read that gets no response is cut off by a timeout that returns an error.

Parameters:
- NUM_REQ, 2, number of upstream masters (2..8)
- ADDR_W, 16, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles from rreq handshake to rack handshake before an error response; 0 disables the timeout

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- m_rreq_addr  in  NUM_REQ*ADDR_W  per-master read address, master i in slice i
- m_rreq_vld  in  NUM_REQ  per-master read request valid
- m_rreq_rdy  out  NUM_REQ  read request accepted
- m_rack_data  out  NUM_REQ*DATA_W  read response data
- m_rack_err  out  NUM_REQ  read response is a timeout error
- m_rack_vld  out  NUM_REQ  read response valid
- m_rack_rdy  in  NUM_REQ  master ready for read response
- m_wreq_addr  in  NUM_REQ*ADDR_W  write address
- m_wreq_data  in  NUM_REQ*DATA_W  write data (already byte-masked)
- m_wreq_vld  in  NUM_REQ  write request valid
- m_wreq_rdy  out  NUM_REQ  write accepted
- s_rreq_addr  out  ADDR_W  to register space
- s_rreq_vld  out  1
- s_rreq_rdy  in  1
- s_rack_data  in  DATA_W
- s_rack_vld  in  1
- s_rack_rdy  out  1
- s_wreq_addr  out  ADDR_W
- s_wreq_data  out  DATA_W
- s_wreq_vld  out  1
- s_wreq_rdy  in  1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset:
  - Single clock clk. Reset rst is synchronous and active-high.
  - Reset forces state IDLE, grant pointer to 0, timeout counter to 0, and every output to 0.
  - Reset asserted mid-transaction abandons that transaction; no response is issued for it.
- Master protocol: each master holds vld, addr and data stable until its rdy is seen high.
- Arbitration (IDLE only):
  - A master is eligible if its rreq_vld or wreq_vld is high.
  - Round-robin search starts at rr_ptr; the first eligible master wins.
  - If the winner has both vld bits high, its write is taken first.
  - The winner index and op are registered. Next state is WR or RD_REQ.
  - Arbitration latency: 1 cycle from vld to first s_*_vld.
- WR:
  - s_wreq_* is driven from the granted master's slices and s_wreq_vld=1.
  - m_wreq_rdy[g] = s_wreq_rdy, combinational pass-through.
  - On handshake: rr_ptr <= g+1 mod NUM_REQ, go to IDLE.
- RD_REQ:
  - s_rreq_* is driven from master g and s_rreq_vld=1. m_rreq_rdy[g] = s_rreq_rdy.
  - On handshake: clear the timeout counter, go to RD_ACK.
- RD_ACK:
  - s_rack_rdy = m_rack_rdy[g].
  - m_rack_vld[g] = s_rack_vld and m_rack_data[g] = s_rack_data, both combinational, with m_rack_err[g]=0.
  - On handshake: advance rr_ptr, go to IDLE.
  - The counter increments each cycle with no s_rack_vld. When it reaches TIMEOUT (TIMEOUT≠0), go to RD_ERR.
- RD_ERR:
  - m_rack_vld[g]=1, m_rack_err[g]=1, m_rack_data[g]=0.
  - Held until m_rack_rdy[g]; then advance rr_ptr and go to IDLE.
  - A late s_rack_vld in this state is absorbed: s_rack_rdy=1, data dropped.
- Idle drive: ungranted masters' rdy/vld/err outputs are 0 and their data outputs are 0. s_* vld outputs are 0 in IDLE.
- Simultaneous events:
  - Requests arriving during a transaction wait; they are never lost because masters hold vld.
  - A master that drops vld before the grant registers is treated as a protocol violation.
  - If a request is withdrawn in the grant cycle, the arbiter still issues it.
- rr_ptr wraps modulo NUM_REQ. The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates.

Decomposition:
- Package regspace_arb_pkg holds:
  - the state enum (IDLE, WR, RD_REQ, RD_ACK, RD_ERR);
  - ERR_DATA = 0;
  - a function for round-robin next-index.
- One sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req vector and ptr. Outputs: one-hot and index.
  - Reusable by other interconnect blocks.

Test Plan:
- NUM_REQ=2, only master0 writes addr 0x0004 data 0xA5A5_0001, s_wreq_rdy=1 → s_wreq_vld high 1 cycle after m_wreq_vld, s_wreq_addr=0x0004, m_wreq_rdy[0] for 1 cycle, busy returns 0.
- Both masters read in the same cycle (0x0000 and 0x0008), slave responds 0x11 and 0x22 after 2 cycles each → master0 served first, gets 0x11; master1 then gets 0x22; a second simultaneous pair starts with master1.
- Master0 asserts read and write together → write is issued first, then after re-arbitration the read is issued.
- TIMEOUT=4, s_rack_vld never asserted → m_rack_vld[0]=1, m_rack_err[0]=1, data 0 on the 5th cycle after the rreq handshake; a late s_rack_vld is absorbed with no m_rack_vld pulse.
- Master holds m_rack_rdy=0 for 3 cycles while s_rack_vld=1 → s_rack_rdy stays 0, data stable, and completion happens on the cycle rdy rises.
- rst pulsed while in RD_ACK → next cycle state IDLE, all outputs 0, rr_ptr=0, and the next request arbitrates normally.

Source files
------------

// File: rtl/regspace_arb_pkg.sv
// Shared types and helpers for the register-space request arbiter and
// other interconnect blocks that need round-robin ordering.
package regspace_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_ACK,
    ST_RD_ERR
  } arb_state_e;

  localparam int unsigned ERR_DATA = 0;

  // Index following idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set bit of req at or after
// ptr (wrapping) wins; reported as one-hot and as an index.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regspace_req_arbiter.sv
// Shares one split-channel register-space slave port between NUM_REQ masters
// with round-robin arbitration, one transaction in flight and a read timeout.
module regspace_req_arbiter
  import regspace_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] m_rreq_addr,
  input  logic [NUM_REQ-1:0]        m_rreq_vld,
  output logic [NUM_REQ-1:0]        m_rreq_rdy,
  output logic [NUM_REQ*DATA_W-1:0] m_rack_data,
  output logic [NUM_REQ-1:0]        m_rack_err,
  output logic [NUM_REQ-1:0]        m_rack_vld,
  input  logic [NUM_REQ-1:0]        m_rack_rdy,
  input  logic [NUM_REQ*ADDR_W-1:0] m_wreq_addr,
  input  logic [NUM_REQ*DATA_W-1:0] m_wreq_data,
  input  logic [NUM_REQ-1:0]        m_wreq_vld,
  output logic [NUM_REQ-1:0]        m_wreq_rdy,
  output logic [ADDR_W-1:0]         s_rreq_addr,
  output logic                      s_rreq_vld,
  input  logic                      s_rreq_rdy,
  input  logic [DATA_W-1:0]         s_rack_data,
  input  logic                      s_rack_vld,
  output logic                      s_rack_rdy,
  output logic [ADDR_W-1:0]         s_wreq_addr,
  output logic [DATA_W-1:0]         s_wreq_data,
  output logic                      s_wreq_vld,
  input  logic                      s_wreq_rdy,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   ptr_next;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (m_rreq_vld | m_wreq_vld),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    ptr_next  = IDX_W'(rr_next(32'(gnt_q), NUM_REQ));

    m_rreq_rdy  = '0;
    m_rack_data = '0;
    m_rack_err  = '0;
    m_rack_vld  = '0;
    m_wreq_rdy  = '0;
    s_rreq_addr = '0;
    s_rreq_vld  = 1'b0;
    s_rack_rdy  = 1'b0;
    s_wreq_addr = '0;
    s_wreq_data = '0;
    s_wreq_vld  = 1'b0;
    busy        = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // A winner holding both requests is issued as a write first.
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = (|(pick_gnt & m_wreq_vld)) ? ST_WR : ST_RD_REQ;
        end
      end

      ST_WR: begin
        s_wreq_addr       = m_wreq_addr[32'(gnt_q)*ADDR_W +: ADDR_W];
        s_wreq_data       = m_wreq_data[32'(gnt_q)*DATA_W +: DATA_W];
        s_wreq_vld        = 1'b1;
        m_wreq_rdy[gnt_q] = s_wreq_rdy;
        if (s_wreq_rdy) begin
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        s_rreq_addr       = m_rreq_addr[32'(gnt_q)*ADDR_W +: ADDR_W];
        s_rreq_vld        = 1'b1;
        m_rreq_rdy[gnt_q] = s_rreq_rdy;
        if (s_rreq_rdy) begin
          tmo_cnt_d = '0;
          state_d   = ST_RD_ACK;
        end
      end

      ST_RD_ACK: begin
        s_rack_rdy                                 = m_rack_rdy[gnt_q];
        m_rack_vld[gnt_q]                          = s_rack_vld;
        m_rack_data[32'(gnt_q)*DATA_W +: DATA_W]   = s_rack_data;
        if (s_rack_vld) begin
          if (m_rack_rdy[gnt_q]) begin
            rr_ptr_d = ptr_next;
            state_d  = ST_IDLE;
          end
        end else begin
          if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
          if (TIMEOUT != 0 && tmo_cnt_d == TMO_VAL) begin
            state_d = ST_RD_ERR;
          end
        end
      end

      ST_RD_ERR: begin
        // Late slave responses are swallowed here so the slave never stalls.
        s_rack_rdy                               = 1'b1;
        m_rack_vld[gnt_q]                        = 1'b1;
        m_rack_err[gnt_q]                        = 1'b1;
        m_rack_data[32'(gnt_q)*DATA_W +: DATA_W] = DATA_W'(ERR_DATA);
        if (m_rack_rdy[gnt_q]) begin
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_regspace_req_arbiter.sv
// Directed bench for regspace_req_arbiter with NUM_REQ=2 and TIMEOUT=4.
module tb_regspace_req_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  m_rreq_addr;
  logic [NR-1:0]     m_rreq_vld;
  logic [NR-1:0]     m_rreq_rdy;
  logic [NR*DW-1:0]  m_rack_data;
  logic [NR-1:0]     m_rack_err;
  logic [NR-1:0]     m_rack_vld;
  logic [NR-1:0]     m_rack_rdy;
  logic [NR*AW-1:0]  m_wreq_addr;
  logic [NR*DW-1:0]  m_wreq_data;
  logic [NR-1:0]     m_wreq_vld;
  logic [NR-1:0]     m_wreq_rdy;
  logic [AW-1:0]     s_rreq_addr;
  logic              s_rreq_vld;
  logic              s_rreq_rdy;
  logic [DW-1:0]     s_rack_data;
  logic              s_rack_vld;
  logic              s_rack_rdy;
  logic [AW-1:0]     s_wreq_addr;
  logic [DW-1:0]     s_wreq_data;
  logic              s_wreq_vld;
  logic              s_wreq_rdy;
  logic              busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  regspace_req_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_rreq_addr (m_rreq_addr),
    .m_rreq_vld  (m_rreq_vld),
    .m_rreq_rdy  (m_rreq_rdy),
    .m_rack_data (m_rack_data),
    .m_rack_err  (m_rack_err),
    .m_rack_vld  (m_rack_vld),
    .m_rack_rdy  (m_rack_rdy),
    .m_wreq_addr (m_wreq_addr),
    .m_wreq_data (m_wreq_data),
    .m_wreq_vld  (m_wreq_vld),
    .m_wreq_rdy  (m_wreq_rdy),
    .s_rreq_addr (s_rreq_addr),
    .s_rreq_vld  (s_rreq_vld),
    .s_rreq_rdy  (s_rreq_rdy),
    .s_rack_data (s_rack_data),
    .s_rack_vld  (s_rack_vld),
    .s_rack_rdy  (s_rack_rdy),
    .s_wreq_addr (s_wreq_addr),
    .s_wreq_data (s_wreq_data),
    .s_wreq_vld  (s_wreq_vld),
    .s_wreq_rdy  (s_wreq_rdy),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ctl_flags();
    return {m_rreq_rdy, m_rack_vld, m_wreq_rdy, s_rreq_vld, s_wreq_vld};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    m_rreq_addr = '0;
    m_rreq_vld  = '0;
    m_rack_rdy  = 2'b11;
    m_wreq_addr = '0;
    m_wreq_data = '0;
    m_wreq_vld  = '0;
    s_rreq_rdy  = 1'b1;
    s_rack_data = '0;
    s_rack_vld  = 1'b0;
    s_wreq_rdy  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ctl", 64'({ctl_flags(), m_rack_err, s_rack_rdy}), 64'd0);
    check("reset_data", 64'(m_rack_data), 64'd0);

    // Both masters read together: master0 first, then master1.
    m_rreq_addr = {16'h0008, 16'h0000};
    m_rreq_vld  = 2'b11;
    tick();
    check("rd0_svld", 64'(s_rreq_vld), 64'd1);
    check("rd0_addr", 64'(s_rreq_addr), 64'h0000);
    check("rd0_mrdy", 64'(m_rreq_rdy), 64'b01);
    tick();
    m_rreq_vld = 2'b10;
    #1;
    check("rd0_ack_wait", 64'({s_rreq_vld, m_rack_vld}), 64'd0);
    check("rd0_srack_rdy", 64'(s_rack_rdy), 64'd1);
    tick();
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h11;
    #1;
    check("rd0_mvld", 64'(m_rack_vld), 64'b01);
    check("rd0_data", 64'(m_rack_data), {32'h0, 32'h11});
    check("rd0_err", 64'(m_rack_err), 64'd0);
    tick();
    s_rack_vld = 1'b0;
    #1;
    check("rd0_done_busy", 64'(busy), 64'd0);
    tick();
    check("rd1_addr", 64'(s_rreq_addr), 64'h0008);
    check("rd1_mrdy", 64'(m_rreq_rdy), 64'b10);
    tick();
    m_rreq_vld = 2'b00;
    tick();
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h22;
    #1;
    check("rd1_mvld", 64'(m_rack_vld), 64'b10);
    check("rd1_data", 64'(m_rack_data), {32'h22, 32'h0});
    tick();
    s_rack_vld = 1'b0;

    // Single write from master0.
    m_wreq_addr = {16'h0, 16'h0004};
    m_wreq_data = {32'h0, 32'hA5A5_0001};
    m_wreq_vld  = 2'b01;
    #1;
    check("wr_no_early_vld", 64'(s_wreq_vld), 64'd0);
    tick();
    check("wr_svld", 64'(s_wreq_vld), 64'd1);
    check("wr_addr", 64'(s_wreq_addr), 64'h0004);
    check("wr_data", 64'(s_wreq_data), 64'hA5A5_0001);
    check("wr_mrdy", 64'(m_wreq_rdy), 64'b01);
    check("wr_busy", 64'(busy), 64'd1);
    tick();
    m_wreq_vld = 2'b00;
    #1;
    check("wr_done", 64'({s_wreq_vld, m_wreq_rdy, busy}), 64'd0);

    // Second simultaneous pair: pointer now favours master1.
    m_rreq_addr = {16'h0014, 16'h0010};
    m_rreq_vld  = 2'b11;
    tick();
    check("pair2_first_addr", 64'(s_rreq_addr), 64'h0014);
    check("pair2_first_mrdy", 64'(m_rreq_rdy), 64'b10);
    tick();
    m_rreq_vld  = 2'b01;
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h33;
    #1;
    check("pair2_first_mvld", 64'(m_rack_vld), 64'b10);
    tick();
    s_rack_vld = 1'b0;
    tick();
    check("pair2_second_addr", 64'(s_rreq_addr), 64'h0010);
    check("pair2_second_mrdy", 64'(m_rreq_rdy), 64'b01);
    tick();
    m_rreq_vld  = 2'b00;
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h44;
    #1;
    check("pair2_second_data", 64'(m_rack_data), {32'h0, 32'h44});
    tick();
    s_rack_vld = 1'b0;

    // Master0 read and write together: write goes first.
    m_wreq_addr = {16'h0, 16'h0020};
    m_wreq_data = {32'h0, 32'hDEAD_BEEF};
    m_wreq_vld  = 2'b01;
    m_rreq_addr = {16'h0, 16'h0024};
    m_rreq_vld  = 2'b01;
    tick();
    check("rw_wr_first", 64'({s_wreq_vld, s_rreq_vld}), 64'b10);
    check("rw_wr_addr", 64'(s_wreq_addr), 64'h0020);
    check("rw_no_rrdy", 64'(m_rreq_rdy), 64'd0);
    tick();
    m_wreq_vld = 2'b00;
    #1;
    check("rw_idle", 64'(busy), 64'd0);
    tick();
    check("rw_rd_vld", 64'(s_rreq_vld), 64'd1);
    check("rw_rd_addr", 64'(s_rreq_addr), 64'h0024);
    tick();
    m_rreq_vld  = 2'b00;
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h55;
    #1;
    check("rw_rd_data", 64'(m_rack_data), {32'h0, 32'h55});
    tick();
    s_rack_vld = 1'b0;

    // Timeout: no response; error appears on the 5th cycle after handshake.
    m_rack_rdy  = 2'b00;
    m_rreq_addr = {16'h0, 16'h0030};
    m_rreq_vld  = 2'b01;
    tick();
    check("tmo_req", 64'(s_rreq_vld), 64'd1);
    tick();
    m_rreq_vld = 2'b00;
    #1;
    check("tmo_cyc1", 64'(m_rack_vld), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("tmo_cyc%0d", i), 64'(m_rack_vld), 64'd0);
    end
    tick();
    check("tmo_err_vld", 64'(m_rack_vld), 64'b01);
    check("tmo_err_flag", 64'(m_rack_err), 64'b01);
    check("tmo_err_data", 64'(m_rack_data), 64'd0);
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h99;
    #1;
    check("tmo_late_absorb", 64'(s_rack_rdy), 64'd1);
    check("tmo_late_data", 64'(m_rack_data), 64'd0);
    tick();
    s_rack_vld = 1'b0;
    check("tmo_err_hold", 64'({m_rack_vld, m_rack_err}), 64'b0101);
    m_rack_rdy = 2'b01;
    tick();
    check("tmo_done", 64'({m_rack_vld, m_rack_err, busy}), 64'd0);

    // Response held off by master backpressure for 3 cycles.
    m_rack_rdy  = 2'b00;
    m_rreq_addr = {16'h0, 16'h0040};
    m_rreq_vld  = 2'b01;
    tick();
    tick();
    m_rreq_vld  = 2'b00;
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_srdy_%0d", i), 64'(s_rack_rdy), 64'd0);
      check($sformatf("bp_data_%0d", i), 64'({m_rack_vld, m_rack_err, m_rack_data}),
            {28'd0, 2'b01, 2'b00, 32'h0, 32'h66});
      tick();
    end
    m_rack_rdy = 2'b01;
    #1;
    check("bp_release", 64'(s_rack_rdy), 64'd1);
    tick();
    s_rack_vld = 1'b0;
    #1;
    check("bp_done", 64'(busy), 64'd0);

    // Reset during RD_ACK abandons the read and resets the pointer.
    m_rack_rdy  = 2'b11;
    m_rreq_addr = {16'h0054, 16'h0050};
    m_rreq_vld  = 2'b01;
    tick();
    tick();
    m_rreq_vld = 2'b00;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_ctl", 64'({ctl_flags(), m_rack_err, s_rack_rdy, busy}), 64'd0);
    check("rst_mid_data", 64'(m_rack_data), 64'd0);
    m_rreq_vld = 2'b11;
    tick();
    check("rst_rearb_mrdy", 64'(m_rreq_rdy), 64'b01);
    check("rst_rearb_addr", 64'(s_rreq_addr), 64'h0050);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
